// File: rtl/child_rr_scheduler.sv
// child_rr_scheduler
//
// Round-robin scheduler that shares one resource among the child instances of
// a hierarchy level. Exactly one child owns the resource at a time. The owner
// keeps it until it pulses done, drops its request, or reaches the hold limit.
// After every release there is one dead cycle before the next grant appears.
//
// Parameters
//   NUM_REQ   number of requesting children (>= 2)
//   MAX_HOLD  maximum number of cycles a grant may stay high (>= 2)
//   IDW       width of grant_id, derived from NUM_REQ
//
// Ports
//   clk            rising-edge clock for all logic
//   rst            synchronous active-high reset, overrides everything else
//   req            per-child level-sensitive request
//   done           per-child one-cycle release strobe (owner only)
//   grant          registered one-hot grant
//   grant_valid    OR of grant
//   grant_id       index of the granted child, 0 while nothing is granted
//   timeout_pulse  one-cycle pulse in the last cycle of a forced release
//   busy           high while a grant is held or in the dead cycle after it

module child_rr_scheduler #(
   parameter  int NUM_REQ  = 5,
   parameter  int MAX_HOLD = 16,
   localparam int IDW      = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [IDW-1:0]     grant_id,
   output logic               timeout_pulse,
   output logic               busy
);

   localparam int HCW = $clog2(MAX_HOLD);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RELEASE
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [NUM_REQ-1:0]   grant_next;
   logic [IDW-1:0]       grant_id_next;
   logic [HCW-1:0]       hold_cnt;
   logic [HCW-1:0]       hold_cnt_next;
   logic [IDW-1:0]       ptr;
   logic [IDW-1:0]       ptr_next;

   logic                 win_found;
   logic [IDW-1:0]       win_id;
   logic [IDW-1:0]       win_ptr;
   int                   idx;

   logic                 owner_req;
   logic                 owner_done;
   logic                 hold_limit;
   logic                 release_now;

   // Rotating priority search: start at ptr, walk upward with wrap-around and
   // take the first requesting child. The pointer then moves just past the
   // winner so that child has lowest priority in the next round.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_id    = IDW'(idx);
         end
      end
      win_ptr = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
   end

   // The owner's req/done are picked out by masking with the one-hot grant, so
   // done from any other child has no effect. done seen while still arbitrating
   // (IDLE/RELEASE) is ignored because only the GRANT state looks at it.
   always_comb begin
      owner_req   = |(req & grant);
      owner_done  = |(done & grant);
      hold_limit  = (hold_cnt == HCW'(MAX_HOLD - 1));
      release_now = owner_done | ~owner_req | hold_limit;
   end

   // Next-state and next-output logic for the scheduler FSM.
   always_comb begin
      state_next    = state;
      grant_next    = grant;
      grant_id_next = grant_id;
      hold_cnt_next = hold_cnt;
      ptr_next      = ptr;
      case (state)
         IDLE, RELEASE: begin
            hold_cnt_next = '0;
            if (win_found) begin
               state_next    = GRANT;
               grant_next    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
               grant_id_next = win_id;
               ptr_next      = win_ptr;
            end else begin
               state_next    = IDLE;
               grant_next    = '0;
               grant_id_next = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_next    = RELEASE;
               grant_next    = '0;
               grant_id_next = '0;
               hold_cnt_next = '0;
            end else begin
               hold_cnt_next = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_next    = IDLE;
            grant_next    = '0;
            grant_id_next = '0;
            hold_cnt_next = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         hold_cnt <= '0;
         ptr      <= '0;
      end else begin
         state    <= state_next;
         grant    <= grant_next;
         grant_id <= grant_id_next;
         hold_cnt <= hold_cnt_next;
         ptr      <= ptr_next;
      end
   end

   // The timeout pulse flags only a release forced by the hold limit: the
   // owner is still requesting and has not pulsed done in that same cycle.
   always_comb begin
      timeout_pulse = ~rst & (state == GRANT) & hold_limit & owner_req & ~owner_done;
      grant_valid   = |grant;
      busy          = (state != IDLE);
   end

endmodule

// File: tb/tb_child_rr_scheduler.sv
// tb_child_rr_scheduler
//
// Self-checking bench for child_rr_scheduler with NUM_REQ=5, MAX_HOLD=16.
// A behavioural model tracks the current owner, how many cycles it has held
// the grant, the rotating priority start and the dead cycle after a release.

module tb_child_rr_scheduler;

   localparam int N   = 5;
   localparam int MH  = 16;
   localparam int IDW = $clog2(N);

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           timeout_pulse;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   int m_owner = -1;
   int m_held  = 0;
   int m_dead  = 0;
   int m_ptr   = 0;

   logic obs_to;
   logic exp_to;

   child_rr_scheduler #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .done          (done),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .timeout_pulse (timeout_pulse),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: advance one clock given this cycle's inputs.
   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
      if (rs) begin
         m_owner = -1;
         m_held  = 0;
         m_dead  = 0;
         m_ptr   = 0;
      end else if (m_owner >= 0) begin
         if (d[m_owner] || !r[m_owner] || m_held == MH) begin
            m_owner = -1;
            m_held  = 0;
            m_dead  = 1;
         end else begin
            m_held++;
         end
      end else begin
         m_dead = 0;
         for (int i = 0; i < N; i++) begin
            if (m_owner < 0 && r[(m_ptr + i) % N]) begin
               m_owner = (m_ptr + i) % N;
               m_held  = 1;
            end
         end
         if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
      end
   endtask

   function automatic logic [N-1:0] exp_grant();
      if (m_owner < 0) return '0;
      return N'(1) << m_owner;
   endfunction

   function automatic logic [IDW-1:0] exp_id();
      if (m_owner < 0) return '0;
      return IDW'(m_owner);
   endfunction

   function automatic logic exp_busy();
      return (m_owner >= 0) || (m_dead != 0);
   endfunction

   // Drive one cycle: inputs change just after a rising edge, the
   // combinational timeout is sampled mid-cycle, registered outputs #1 after
   // the next edge.
   task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
      req  = r;
      done = d;
      rst  = rs;
      #1;
      obs_to = timeout_pulse;
      exp_to = !rs && m_owner >= 0 && m_held == MH && r[m_owner] && !d[m_owner];
      @(posedge clk);
      model_step(r, d, rs);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus('0, '0, 1'b1);
      applyStimulus(5'b11111, 5'b11111, 1'b1);
      checks++; if (grant !== 5'b0) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=%b", grant, 5'b0); end
      checks++; if (grant_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", grant_valid); end
      checks++; if (grant_id !== '0) begin failures++; $display("[TB] FAIL reset_id got=%0d exp=0", grant_id); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (obs_to !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout got=%b exp=0", obs_to); end
   endtask

   task automatic test_single();
      applyStimulus('0, '0, 1'b1);
      applyStimulus(5'b00100, '0, 1'b0);
      checks++; if (grant !== 5'b00100) begin failures++; $display("[TB] FAIL single_grant got=%b exp=00100", grant); end
      checks++; if (grant_id !== 3'd2) begin failures++; $display("[TB] FAIL single_id got=%0d exp=2", grant_id); end
      applyStimulus(5'b00100, 5'b00100, 1'b0);
      checks++; if (grant !== 5'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL single_release grant=%b busy=%b exp grant=00000 busy=1", grant, busy); end
      applyStimulus('0, '0, 1'b0);
      checks++; if (busy !== 1'b0 || grant !== 5'b0) begin failures++; $display("[TB] FAIL single_idle grant=%b busy=%b exp grant=00000 busy=0", grant, busy); end
   endtask

   task automatic test_fairness();
      int order[$];
      int exp_order[6] = '{0, 1, 2, 3, 4, 0};
      logic [N-1:0] d;
      logic prev_valid;
      applyStimulus('0, '0, 1'b1);
      prev_valid = 1'b0;
      for (int c = 0; c < 18; c++) begin
         d = '0;
         if (m_owner >= 0 && m_held == 2) d[m_owner] = 1'b1;
         applyStimulus(5'b11111, d, 1'b0);
         checks++; if (grant !== exp_grant()) begin failures++; $display("[TB] FAIL fair_grant cyc=%0d got=%b exp=%b", c, grant, exp_grant()); end
         if (grant_valid && !prev_valid) order.push_back(int'(grant_id));
         prev_valid = grant_valid;
      end
      checks++; if (order.size() != 6) begin failures++; $display("[TB] FAIL fair_count got=%0d exp=6", order.size()); end
      for (int i = 0; i < 6 && i < order.size(); i++) begin
         checks++; if (order[i] != exp_order[i]) begin failures++; $display("[TB] FAIL fair_order pos=%0d got=%0d exp=%0d", i, order[i], exp_order[i]); end
      end
   endtask

   task automatic test_timeout();
      int high_cnt;
      int to_cnt;
      applyStimulus('0, '0, 1'b1);
      high_cnt = 0;
      to_cnt   = 0;
      for (int c = 0; c < 17; c++) begin
         applyStimulus(5'b00001, '0, 1'b0);
         if (grant[0]) high_cnt++;
         if (obs_to) to_cnt++;
         checks++; if (obs_to !== exp_to) begin failures++; $display("[TB] FAIL to_pulse cyc=%0d got=%b exp=%b", c, obs_to, exp_to); end
      end
      checks++; if (high_cnt != MH) begin failures++; $display("[TB] FAIL to_hold got=%0d exp=%0d", high_cnt, MH); end
      checks++; if (to_cnt != 1) begin failures++; $display("[TB] FAIL to_count got=%0d exp=1", to_cnt); end
      checks++; if (grant !== 5'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL to_release grant=%b busy=%b exp grant=00000 busy=1", grant, busy); end
      applyStimulus(5'b00001, '0, 1'b0);
      checks++; if (grant !== 5'b00001) begin failures++; $display("[TB] FAIL to_regrant got=%b exp=00001", grant); end
   endtask

   task automatic test_wrap();
      applyStimulus('0, '0, 1'b1);
      applyStimulus(5'b01000, '0, 1'b0);
      checks++; if (grant !== 5'b01000) begin failures++; $display("[TB] FAIL wrap_g3 got=%b exp=01000", grant); end
      applyStimulus(5'b00000, '0, 1'b0);
      checks++; if (grant !== 5'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL wrap_drop grant=%b busy=%b exp grant=00000 busy=1", grant, busy); end
      applyStimulus(5'b01001, '0, 1'b0);
      checks++; if (grant !== 5'b00001) begin failures++; $display("[TB] FAIL wrap_g0 got=%b exp=00001", grant); end
      applyStimulus(5'b01001, 5'b00001, 1'b0);
      applyStimulus(5'b01001, '0, 1'b0);
      checks++; if (grant !== 5'b01000 || grant_id !== 3'd3) begin failures++; $display("[TB] FAIL wrap_g3b grant=%b id=%0d exp grant=01000 id=3", grant, grant_id); end
   endtask

   task automatic test_stray_done();
      int high_cnt;
      applyStimulus('0, '0, 1'b1);
      applyStimulus(5'b01000, '0, 1'b0);
      high_cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         applyStimulus(5'b01000, (c % 3 == 1) ? 5'b00010 : 5'b00000, 1'b0);
         if (grant[3]) high_cnt++;
         checks++; if (grant !== exp_grant()) begin failures++; $display("[TB] FAIL stray_grant cyc=%0d got=%b exp=%b", c, grant, exp_grant()); end
         checks++; if (obs_to !== exp_to) begin failures++; $display("[TB] FAIL stray_to cyc=%0d got=%b exp=%b", c, obs_to, exp_to); end
      end
      checks++; if (high_cnt != MH - 1) begin failures++; $display("[TB] FAIL stray_hold got=%0d exp=%0d", high_cnt, MH - 1); end
   endtask

   task automatic test_mid_reset();
      applyStimulus('0, '0, 1'b1);
      applyStimulus(5'b11111, '0, 1'b0);
      applyStimulus(5'b11111, 5'b00001, 1'b0);
      applyStimulus(5'b11111, '0, 1'b0);
      for (int c = 0; c < 5; c++) applyStimulus(5'b11111, '0, 1'b0);
      checks++; if (grant !== 5'b00010) begin failures++; $display("[TB] FAIL midrst_pre got=%b exp=00010", grant); end
      applyStimulus(5'b11111, '0, 1'b1);
      checks++; if (grant !== 5'b0 || grant_valid !== 1'b0 || grant_id !== '0 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_clear grant=%b valid=%b id=%0d busy=%b exp all 0", grant, grant_valid, grant_id, busy);
      end
      applyStimulus(5'b11111, '0, 1'b0);
      checks++; if (grant !== 5'b00001) begin failures++; $display("[TB] FAIL midrst_first got=%b exp=00001", grant); end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [N-1:0] d;
      logic rs;
      applyStimulus('0, '0, 1'b1);
      r = '0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) == 0) r = N'($urandom);
         d  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         rs = ($urandom_range(0, 149) == 0);
         applyStimulus(r, d, rs);
         checks++; if (grant !== exp_grant()) begin failures++; $display("[TB] FAIL rnd_grant cyc=%0d got=%b exp=%b", c, grant, exp_grant()); end
         checks++; if (grant_id !== exp_id()) begin failures++; $display("[TB] FAIL rnd_id cyc=%0d got=%0d exp=%0d", c, grant_id, exp_id()); end
         checks++; if (grant_valid !== (m_owner >= 0)) begin failures++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", c, grant_valid, m_owner >= 0); end
         checks++; if (busy !== exp_busy()) begin failures++; $display("[TB] FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, exp_busy()); end
         checks++; if (obs_to !== exp_to) begin failures++; $display("[TB] FAIL rnd_to cyc=%0d got=%b exp=%b", c, obs_to, exp_to); end
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      done = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_wrap();
      test_stray_done();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
